// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential divider.
package seq_div_pkg;

    localparam int SEQ_DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_sub_stage.sv
// Trial subtractor a - b as a ripple adder of a, ~b and carry-in 1.
// The final carry out is set when the subtraction does not borrow.
module div_sub_stage #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         no_borrow
);

    logic [W:0]   carry;
    logic [W-1:0] b_n;

    assign b_n      = ~b;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign diff[i]    = a[i] ^ b_n[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b_n[i]) | (carry[i] & (a[i] ^ b_n[i]));
    end

    assign no_borrow = carry[W];

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, MSB first.
// Defining SEQ_DIV_DBZ_EN adds the div_zero port and a one-cycle divide-by-zero path.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = SEQ_DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef SEQ_DIV_DBZ_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;
`ifdef SEQ_DIV_DBZ_EN
    logic             dz_q, dz_d;
`endif

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             no_borrow;

    // Partial remainder stays below the divisor, so its top bit shifts out as zero.
    assign shifted = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};

    div_sub_stage #(.W(WIDTH + 1)) u_sub (
        .a         (shifted),
        .b         ({1'b0, dvs_q}),
        .diff      (diff),
        .no_borrow (no_borrow)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
`ifdef SEQ_DIV_DBZ_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SEQ_DIV_DBZ_EN
                    dz_d    = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        remo_d  = dividend;
                        dz_d    = 1'b1;
                    end
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                dvd_d = dvd_q << 1;
                rem_d = no_borrow ? diff : shifted;
                acc_d = (acc_q << 1) | {{(WIDTH-1){1'b0}}, no_borrow};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    quo_d   = acc_d;
                    remo_d  = rem_d[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
`ifdef SEQ_DIV_DBZ_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
`ifdef SEQ_DIV_DBZ_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = remo_q;
`ifdef SEQ_DIV_DBZ_EN
    assign div_zero  = dz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=4; covers both SEQ_DIV_DBZ_EN builds.
module tb_seq_divider;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
`ifdef SEQ_DIV_DBZ_EN
    logic             div_zero;
`endif

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
`ifdef SEQ_DIV_DBZ_EN
        .remainder (remainder),
        .div_zero  (div_zero)
`else
        .remainder (remainder)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic start_now(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen (bounded) and RUN cycles seen on the way.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!done && lat < 20) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    int lat, bc;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_quo", 32'(quotient), 0);
        check("rst_rem", 32'(remainder), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 13 / 3
        start_now(4'd13, 4'd3);
        wait_done(lat, bc);
        check("13_3_lat", 32'(lat), 4);
        check("13_3_busy", 32'(bc), 4);
        check("13_3_quo", 32'(quotient), 4);
        check("13_3_rem", 32'(remainder), 1);
        @(posedge clk);
        #1;
        check("13_3_done_pulse", 32'(done), 0);
        check("13_3_idle_busy", 32'(busy), 0);
        check("13_3_hold_quo", 32'(quotient), 4);

        // 15 / 1 then 7 / 9 from the DONE cycle
        start_now(4'd15, 4'd1);
        wait_done(lat, bc);
        check("15_1_lat", 32'(lat), 4);
        check("15_1_quo", 32'(quotient), 15);
        check("15_1_rem", 32'(remainder), 0);
        start_now(4'd7, 4'd9);
        check("b2b_busy", 32'(busy), 1);
        wait_done(lat, bc);
        check("7_9_lat", 32'(lat), 4);
        check("7_9_quo", 32'(quotient), 0);
        check("7_9_rem", 32'(remainder), 7);
        @(posedge clk);
        #1;

        // 9 / 0
        start_now(4'd9, 4'd0);
        wait_done(lat, bc);
`ifdef SEQ_DIV_DBZ_EN
        check("9_0_lat", 32'(lat), 0);
        check("9_0_dz", 32'(div_zero), 1);
`else
        check("9_0_lat", 32'(lat), 4);
`endif
        check("9_0_quo", 32'(quotient), 15);
        check("9_0_rem", 32'(remainder), 9);
        @(posedge clk);
        #1;

        // 6 / 2 with an ignored 15 / 15 request during RUN
        start_now(4'd6, 4'd2);
        start_now(4'd15, 4'd15);
        check("ign_busy", 32'(busy), 1);
        wait_done(lat, bc);
        check("6_2_lat", 32'(lat + 1), 4);
        check("6_2_quo", 32'(quotient), 3);
        check("6_2_rem", 32'(remainder), 0);
`ifdef SEQ_DIV_DBZ_EN
        check("6_2_dz_clr", 32'(div_zero), 0);
`endif
        @(posedge clk);
        #1;

        // reset in the 2nd RUN cycle of 12 / 5
        start_now(4'd12, 4'd5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_quo", 32'(quotient), 0);
        check("mid_rst_rem", 32'(remainder), 0);
        bc = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) bc++;
        end
        check("mid_rst_no_done", 32'(bc), 0);
        rst_n = 1'b1;
        start_now(4'd12, 4'd5);
        check("post_rst_busy", 32'(busy), 1);
        wait_done(lat, bc);
        check("12_5_lat", 32'(lat), 4);
        check("12_5_quo", 32'(quotient), 2);
        check("12_5_rem", 32'(remainder), 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
